// File: rtl/pc_seq_pkg.sv
// Shared types and default vectors for the instruction-fetch next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_STALL      = 2'd2,
        ST_HALTED     = 2'd3
    } state_e;

    // Encoded in priority order so "higher priority" is a plain numeric compare.
    typedef enum logic [2:0] {
        RK_NONE   = 3'd0,
        RK_BRANCH = 3'd1,
        RK_JUMP   = 3'd2,
        RK_JR     = 3'd3,
        RK_EXC    = 3'd4
    } redirect_kind_e;

    localparam logic [31:0] DEF_RESET_VECTOR      = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR        = 32'h0000_0080;
    localparam int          DEF_RESET_HOLD_CYCLES = 2;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation and priority selection
// (exception > jr > jump > branch > sequential).
module pc_target_calc
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0]    current_pc,
    input  logic           branch_taken,
    input  logic [31:0]    branch_offset,
    input  logic           jump_en,
    input  logic [25:0]    jump_target,
    input  logic           jr_en,
    input  logic [31:0]    jr_target,
    input  logic           exception,
    output logic           misaligned,
    output redirect_kind_e sel_kind,
    output logic [31:0]    sel_target
);

    logic [31:0] pc4;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;

    assign pc4        = current_pc + 32'd4;
    assign branch_tgt = pc4 + {branch_offset[29:0], 2'b00};
    assign jump_tgt   = {pc4[31:28], jump_target, 2'b00};
    assign misaligned = jr_en && (jr_target[1:0] != 2'b00);

    // NOTE: every output gets a default first so no path through the
    // if-chain leaves a variable unassigned and infers a latch.
    always_comb begin
        sel_kind   = RK_NONE;
        sel_target = pc4;
        if (exception || misaligned) begin
            sel_kind   = RK_EXC;
            sel_target = EXC_VECTOR;
        end else if (jr_en) begin
            sel_kind   = RK_JR;
            sel_target = jr_target;
        end else if (jump_en) begin
            sel_kind   = RK_JUMP;
            sel_target = jump_tgt;
        end else if (branch_taken) begin
            sel_kind   = RK_BRANCH;
            sel_target = branch_tgt;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: reset hold, stall with deferred redirects, halt.
// Optional performance counters enabled by defining PC_SEQ_PERF_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR      = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR        = DEF_EXC_VECTOR,
    parameter int          RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump_en,
    input  logic [25:0] jump_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        exception,
    input  logic        halt,
    output logic [31:0] next_pc,
    output logic        pc_freeze,
    output logic        fetch_valid,
    output logic        redirect_pending,
    output logic        misaligned_err,
    output logic        halted,
    output logic [31:0] retired_count,
    output logic [31:0] stall_count
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic           pend_valid_q, pend_valid_d;
    redirect_kind_e pend_kind_q, pend_kind_d;
    logic [31:0]    pend_target_q, pend_target_d;

    logic           misaligned;
    redirect_kind_e sel_kind;
    logic [31:0]    sel_target;
    logic           go;

    pc_target_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_target_calc (
        .current_pc    (current_pc),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .jr_en         (jr_en),
        .jr_target     (jr_target),
        .exception     (exception),
        .misaligned    (misaligned),
        .sel_kind      (sel_kind),
        .sel_target    (sel_target)
    );

    assign go               = !stall && fetch_ready;
    assign redirect_pending = pend_valid_q;

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        pend_valid_d   = pend_valid_q;
        pend_kind_d    = pend_kind_q;
        pend_target_d  = pend_target_q;
        next_pc        = current_pc;
        pc_freeze      = 1'b1;
        fetch_valid    = 1'b0;
        misaligned_err = 1'b0;
        halted         = 1'b0;

        case (state_q)
            ST_RESET_HOLD: begin
                next_pc   = RESET_VECTOR;
                pc_freeze = 1'b0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN, ST_STALL: begin
                // A STALL release cycle behaves exactly like RUN, halt included.
                if (halt && (state_q == ST_RUN || go)) begin
                    state_d      = ST_HALTED;
                    pend_valid_d = 1'b0;
                    pend_kind_d  = RK_NONE;
                end else if (go) begin
                    state_d        = ST_RUN;
                    pc_freeze      = 1'b0;
                    fetch_valid    = 1'b1;
                    misaligned_err = misaligned;
                    next_pc        = pend_valid_q ? pend_target_q : sel_target;
                    pend_valid_d   = 1'b0;
                    pend_kind_d    = RK_NONE;
                end else begin
                    state_d        = ST_STALL;
                    misaligned_err = misaligned;
                    // Empty pending holds RK_NONE, so any live redirect wins from RUN.
                    if (sel_kind > pend_kind_q) begin
                        pend_valid_d  = 1'b1;
                        pend_kind_d   = sel_kind;
                        pend_target_d = sel_target;
                    end
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RESET_HOLD;
            hold_cnt_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_kind_q   <= RK_NONE;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cycle;

    // A STALL release cycle is a fetch, not a stall.
    assign stall_cycle = pc_freeze && (state_q == ST_RUN || state_q == ST_STALL);

    always_comb begin
        retired_d   = retired_q + 32'(fetch_valid);
        stall_cnt_d = stall_cnt_q + 32'(stall_cycle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_cnt_q;
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expectations,
// a negedge monitor pops and compares one entry per cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, branch_taken, jump_en, jr_en, exception, halt;
    logic [31:0] current_pc, branch_offset, jr_target;
    logic [25:0] jump_target;
    logic [31:0] next_pc, retired_count, stall_count;
    logic        pc_freeze, fetch_valid, redirect_pending, misaligned_err, halted;

    always #5 clk = ~clk;

`ifdef PC_SEQ_PERF_CNT_EN
    localparam logic [31:0] RET_EXP = 32'd5;
    localparam logic [31:0] STL_EXP = 32'd3;
`else
    localparam logic [31:0] RET_EXP = 32'd0;
    localparam logic [31:0] STL_EXP = 32'd0;
`endif

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .current_pc       (current_pc),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .branch_taken     (branch_taken),
        .branch_offset    (branch_offset),
        .jump_en          (jump_en),
        .jump_target      (jump_target),
        .jr_en            (jr_en),
        .jr_target        (jr_target),
        .exception        (exception),
        .halt             (halt),
        .next_pc          (next_pc),
        .pc_freeze        (pc_freeze),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .misaligned_err   (misaligned_err),
        .halted           (halted),
        .retired_count    (retired_count),
        .stall_count      (stall_count)
    );

    typedef struct {
        string       name;
        logic        chk_pc;
        logic [31:0] pc;
        logic        frz, fv, rp, mis, hlt;
        logic        chk_cnt;
        logic [31:0] ret, stl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_miss   = 0;
    bit   stim_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the rising edge and return inputs to a quiet RUN cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
        branch_taken = 1'b0; branch_offset = '0;
        jump_en = 1'b0; jump_target = '0;
        jr_en = 1'b0; jr_target = '0;
        exception = 1'b0; halt = 1'b0;
    endtask

    task automatic exp_out(input string name, input logic chk_pc, input logic [31:0] pc,
                           input logic frz, input logic fv, input logic rp,
                           input logic mis, input logic hlt);
        exp_t e;
        e.name = name; e.chk_pc = chk_pc; e.pc = pc;
        e.frz = frz; e.fv = fv; e.rp = rp; e.mis = mis; e.hlt = hlt;
        e.chk_cnt = 1'b0; e.ret = '0; e.stl = '0;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input logic [31:0] ret, input logic [31:0] stl);
        sb[sb.size()-1].chk_cnt = 1'b1;
        sb[sb.size()-1].ret     = ret;
        sb[sb.size()-1].stl     = stl;
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_pc) check({e.name, ".next_pc"}, next_pc, e.pc);
                check({e.name, ".pc_freeze"},        32'(pc_freeze),        32'(e.frz));
                check({e.name, ".fetch_valid"},      32'(fetch_valid),      32'(e.fv));
                check({e.name, ".redirect_pending"}, 32'(redirect_pending), 32'(e.rp));
                check({e.name, ".misaligned_err"},   32'(misaligned_err),   32'(e.mis));
                check({e.name, ".halted"},           32'(halted),           32'(e.hlt));
                if (e.chk_cnt) begin
                    check({e.name, ".retired_count"}, retired_count, e.ret);
                    check({e.name, ".stall_count"},   stall_count,   e.stl);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; fetch_ready = 1'b1; current_pc = '0;
        branch_taken = 1'b0; branch_offset = '0; jump_en = 1'b0; jump_target = '0;
        jr_en = 1'b0; jr_target = '0; exception = 1'b0; halt = 1'b0;

        // Reset held three cycles, then two RESET_HOLD cycles, then RUN.
        for (int i = 0; i < 3; i++) begin
            cyc(); reset = 1'b1;
            exp_out("rst_asserted", 1, 32'h0, 0, 0, 0, 0, 0);
            if (i == 0) exp_cnt(32'd0, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            exp_out("reset_hold", 1, 32'h0, 0, 0, 0, 0, 0);
        end
        cyc(); current_pc = 32'h0;
        exp_out("first_seq", 1, 32'h4, 0, 1, 0, 0, 0);

        // Branch, then jump beating branch.
        cyc(); current_pc = 32'h100; branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        exp_out("branch_back", 1, 32'hFC, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'h100; branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        jump_en = 1; jump_target = 26'h40;
        exp_out("jump_over_branch", 1, 32'h100, 0, 1, 0, 0, 0);

        // Branch latched at stall, overridden by higher-priority jr during stall.
        cyc(); current_pc = 32'h100; stall = 1; branch_taken = 1; branch_offset = 32'h3F;
        exp_out("stall_latch_br", 0, 32'h0, 1, 0, 0, 0, 0);
        cyc(); current_pc = 32'h100; stall = 1; jr_en = 1; jr_target = 32'h300;
        exp_out("stall_jr_upgrade", 0, 32'h0, 1, 0, 1, 0, 0);
        cyc(); current_pc = 32'h100;
        exp_out("release_jr", 1, 32'h300, 0, 1, 1, 0, 0);
        cyc(); current_pc = 32'h300;
        exp_out("after_release", 1, 32'h304, 0, 1, 0, 0, 0);

        // Jump latched; lower and equal priority redirects during stall ignored.
        cyc(); current_pc = 32'h400; stall = 1; jump_en = 1; jump_target = 26'h123;
        exp_out("stall_latch_j", 0, 32'h0, 1, 0, 0, 0, 0);
        cyc(); current_pc = 32'h400; stall = 1; branch_taken = 1; branch_offset = 32'h4;
        exp_out("stall_lower_br", 0, 32'h0, 1, 0, 1, 0, 0);
        cyc(); current_pc = 32'h400; fetch_ready = 0; jump_en = 1; jump_target = 26'h200;
        exp_out("stall_equal_j", 0, 32'h0, 1, 0, 1, 0, 0);
        cyc(); current_pc = 32'h400;
        exp_out("release_j", 1, 32'h48C, 0, 1, 1, 0, 0);

        // Misaligned jr pulse, exception over jr, PC wrap.
        cyc(); current_pc = 32'h500; jr_en = 1; jr_target = 32'h1002;
        exp_out("jr_misaligned", 1, 32'h80, 0, 1, 0, 1, 0);
        cyc(); current_pc = 32'h500;
        exp_out("mis_one_cycle", 1, 32'h504, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'h500; exception = 1; jr_en = 1; jr_target = 32'h700;
        exp_out("exc_over_jr", 1, 32'h80, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'hFFFF_FFFC;
        exp_out("pc_wrap", 1, 32'h0, 0, 1, 0, 0, 0);

        // Halt beats a simultaneous exception; HALTED ignores exceptions.
        cyc(); current_pc = 32'h600; halt = 1; exception = 1;
        exp_out("halt_req", 0, 32'h0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); current_pc = 32'h600; exception = 1;
            exp_out("halted_hold", 0, 32'h0, 1, 0, 0, 0, 1);
        end
        cyc(); reset = 1; current_pc = 32'h0;
        exp_out("halted_rst", 0, 32'h0, 1, 0, 0, 0, 1);
        cyc();
        exp_out("rst_from_halt", 1, 32'h0, 0, 0, 0, 0, 0);
        exp_cnt(32'd0, 32'd0);
        cyc();
        exp_out("rst_from_halt2", 1, 32'h0, 0, 0, 0, 0, 0);

        // Five valid fetches and three stall cycles for the counters.
        cyc(); current_pc = 32'h0;
        exp_out("cnt_f1", 1, 32'h4, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'h4;
        exp_out("cnt_f2", 1, 32'h8, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); current_pc = 32'h8; stall = 1;
            exp_out("cnt_stall", 0, 32'h0, 1, 0, 0, 0, 0);
        end
        cyc(); current_pc = 32'h8;
        exp_out("cnt_release", 1, 32'hC, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'hC;
        exp_out("cnt_f4", 1, 32'h10, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'h10;
        exp_out("cnt_f5", 1, 32'h14, 0, 1, 0, 0, 0);
        cyc(); current_pc = 32'h14;
        exp_out("cnt_read", 1, 32'h18, 0, 1, 0, 0, 0);
        exp_cnt(RET_EXP, STL_EXP);

        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: stimulus did not finish, expected completion");
        $fatal(1);
    end

endmodule
